// File: rtl/ip_port_arbiter.sv
// ip_port_arbiter: packet-granular round-robin merge of N_REQ injector streams
// onto one router local port. Grant is held from first beat to Last beat, with
// per-source completed-packet counters and a sticky stall watchdog.
//
// state | meaning
// IDLE  | no owner; outputs quiet; picks the next requester after rr_ptr
// LOCK  | owner in grant; its Valid/Data/Last/Ready pass straight through
module ip_port_arbiter #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int STALL_MAX  = 63
) (
    input  logic                        clk,
    input  logic                        nreset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_last,
    input  logic                        out_ready,
    output logic [N_REQ-1:0]            grant,
    output logic [N_REQ*10-1:0]         pkt_cnt,
    output logic                        stall_err
);

    localparam int               IW    = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE   = 1;
    localparam logic [5:0]       SMAX6 = 6'(STALL_MAX);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t                  state;
    logic [IW-1:0]           owner;
    logic [IW-1:0]           rr_ptr;
    logic [N_REQ-1:0][9:0]   cnt_q;
    logic [5:0]              stall_cnt;
    logic [DATA_WIDTH-1:0]   lane [N_REQ];
    logic                    beat;
    logic                    last_beat;
    logic [N_REQ-1:0]        others;
    logic [IW-1:0]           pick_idle;
    logic [IW-1:0]           pick_hand;

    // First set bit of vec searching ptr+1, ptr+2, ... modulo N_REQ.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] vec,
                                              input logic [IW-1:0]    ptr);
        int c;
        rr_pick = ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            c = (int'(ptr) + k) % N_REQ;
            if (vec[IW'(c)]) rr_pick = IW'(c);
        end
    endfunction

    // Split the flat data bus into per-source lanes.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            lane[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Owner pass-through while locked; everything quiet in IDLE.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        req_ready = '0;
        if (state == LOCK) begin
            out_valid        = req_valid[owner];
            out_data         = lane[owner];
            out_last         = req_last[owner];
            req_ready[owner] = out_ready;
        end
    end

    // The owner's Valid on its Last beat belongs to the finishing packet, so it
    // is masked from handover; a lone owner with a follow-on packet re-wins via IDLE.
    always_comb begin
        beat      = out_valid & out_ready;
        last_beat = beat & out_last;
        others    = req_valid & ~grant;
        pick_idle = rr_pick(req_valid, rr_ptr);
        pick_hand = rr_pick(others, owner);
    end

    // Arbitration FSM: lock on grant, hand over with no bubble on Last.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state  <= IDLE;
            grant  <= '0;
            owner  <= '0;
            rr_ptr <= IW'(N_REQ - 1);
        end else if (state == IDLE) begin
            if (|req_valid) begin
                state <= LOCK;
                owner <= pick_idle;
                grant <= ONE << pick_idle;
            end
        end else if (last_beat) begin
            rr_ptr <= owner;
            if (|others) begin
                owner <= pick_hand;
                grant <= ONE << pick_hand;
            end else begin
                state <= IDLE;
                grant <= '0;
            end
        end
    end

    // Completed-packet counters, wrapping at 10 bits.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q <= '0;
        end else if (last_beat) begin
            cnt_q[owner] <= cnt_q[owner] + 10'd1;
        end
    end

    assign pkt_cnt = cnt_q;

    // Stall watchdog: counts locked cycles without a beat, saturates, sticky flag.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stall_cnt <= '0;
            stall_err <= 1'b0;
        end else if (state != LOCK || beat) begin
            stall_cnt <= '0;
        end else begin
            if (stall_cnt != SMAX6) stall_cnt <= stall_cnt + 6'd1;
            if (stall_cnt >= SMAX6 - 6'd1) stall_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ip_port_arbiter.sv
// Directed bench for ip_port_arbiter: table-driven single-packet vectors plus
// hand-written sequences for handover, blocking, stall, owner gaps and reset.
module tb_ip_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            nreset;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic            out_ready;
    logic [N-1:0]    grant;
    logic [N*10-1:0] pkt_cnt;
    logic            stall_err;

    int n_vec = 0;
    int n_err = 0;
    int pk[N];
    int bt[N];

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*DW-1:0] data;
        logic [N-1:0]    last;
        logic            rdy;
        logic [N-1:0]    e_grant;
        logic            e_valid;
        logic [DW-1:0]   e_data;
        logic            e_last;
        logic [N-1:0]    e_ready;
    } vec_t;

    vec_t tbl[6];

    ip_port_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .STALL_MAX(63)) dut (
        .clk(clk), .nreset(nreset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready),
        .grant(grant), .pkt_cnt(pkt_cnt), .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    function automatic logic [N*DW-1:0] lanes(input logic [DW-1:0] w2);
        return {32'h3333_3333, w2, 32'h1111_1111, 32'h0F0F_0F0F};
    endfunction

    function automatic logic [9:0] cnt_of(input int i);
        return pkt_cnt[i*10 +: 10];
    endfunction

    task automatic do_reset;
        nreset    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b1;
        tick;
        tick;
        nreset = 1'b1;
    endtask

    initial begin
        // Single 4-beat packet from source 2 with other lanes carrying junk.
        tbl[0] = '{4'b0100, lanes(32'h2222_0001), 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,          1'b0, 4'b0000};
        tbl[1] = '{4'b0100, lanes(32'h2222_0001), 4'b0000, 1'b1, 4'b0100, 1'b1, 32'h2222_0001, 1'b0, 4'b0100};
        tbl[2] = '{4'b0100, lanes(32'h2222_0002), 4'b0000, 1'b1, 4'b0100, 1'b1, 32'h2222_0002, 1'b0, 4'b0100};
        tbl[3] = '{4'b0100, lanes(32'h2222_0003), 4'b0000, 1'b1, 4'b0100, 1'b1, 32'h2222_0003, 1'b0, 4'b0100};
        tbl[4] = '{4'b0100, lanes(32'h2222_0004), 4'b0100, 1'b1, 4'b0100, 1'b1, 32'h2222_0004, 1'b1, 4'b0100};
        tbl[5] = '{4'b0000, lanes(32'h2222_0005), 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0,          1'b0, 4'b0000};

        do_reset;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_stall", stall_err, 0);

        for (int i = 0; i < 6; i++) begin
            req_valid = tbl[i].valid;
            req_data  = tbl[i].data;
            req_last  = tbl[i].last;
            out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("t%0d_grant", i), grant, tbl[i].e_grant);
            chk($sformatf("t%0d_valid", i), out_valid, tbl[i].e_valid);
            chk($sformatf("t%0d_data", i), out_data, tbl[i].e_data);
            chk($sformatf("t%0d_last", i), out_last, tbl[i].e_last);
            chk($sformatf("t%0d_ready", i), req_ready, tbl[i].e_ready);
            tick;
        end
        chk("t_pkt_cnt2", cnt_of(2), 1);

        // Four sources, two 2-beat packets each: grant order 0,1,2,3,0,... no gaps.
        do_reset;
        for (int i = 0; i < N; i++) begin
            pk[i] = 2;
            bt[i] = 0;
        end
        for (int c = 0; c <= 17; c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = (pk[i] > 0);
                req_last[i]  = (bt[i] == 1);
                req_data[i*DW +: DW] = 32'hC000_0000 | 32'(i << 8) | 32'((2 - pk[i]) << 4) | 32'(bt[i]);
            end
            #1;
            if (c == 0 || c == 17) begin
                chk($sformatf("rr_c%0d_grant", c), grant, 0);
            end else begin
                chk($sformatf("rr_c%0d_grant", c), grant, 4'b0001 << (((c - 1) / 2) % 4));
                chk($sformatf("rr_c%0d_valid", c), out_valid, 1);
                chk($sformatf("rr_c%0d_data", c), out_data,
                    32'hC000_0000 | 32'((((c - 1) / 2) % 4) << 8) | 32'(((c - 1) / 8) << 4) | 32'((c - 1) % 2));
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (bt[i] == 1) begin
                        bt[i] = 0;
                        pk[i]--;
                    end else begin
                        bt[i]++;
                    end
                end
            end
            tick;
        end
        for (int i = 0; i < N; i++) chk($sformatf("rr_pkt_cnt%0d", i), cnt_of(i), 2);

        // Source 1 locked; source 0 requests mid-packet and must wait.
        do_reset;
        req_valid = 4'b0010;
        req_data  = {32'h0, 32'h0, 32'hE000_0000, 32'hF000_0000};
        tick;
        for (int b = 0; b < 3; b++) begin
            req_valid = 4'b0011;
            req_last  = (b == 2) ? 4'b0011 : 4'b0000;
            req_data  = {32'h0, 32'h0, 32'hE000_0000 | 32'(b), 32'hF000_0000};
            #1;
            chk($sformatf("blk_b%0d_grant", b), grant, 4'b0010);
            chk($sformatf("blk_b%0d_data", b), out_data, 32'hE000_0000 | 32'(b));
            chk($sformatf("blk_b%0d_ready", b), req_ready, 4'b0010);
            tick;
        end
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        #1;
        chk("blk_hand_grant", grant, 4'b0001);
        chk("blk_hand_data", out_data, 32'hF000_0000);
        chk("blk_hand_ready", req_ready, 4'b0001);
        chk("blk_hand_last", out_last, 1);
        tick;
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("blk_idle_grant", grant, 0);
        chk("blk_cnt0", cnt_of(0), 1);
        chk("blk_cnt1", cnt_of(1), 1);

        // Stall watchdog: out_ready low for 63 locked cycles.
        do_reset;
        req_valid = 4'b0100;
        req_data  = lanes(32'h2222_00A0);
        out_ready = 1'b0;
        tick;
        for (int k = 0; k < 62; k++) tick;
        #1;
        chk("stall_62", stall_err, 0);
        tick;
        #1;
        chk("stall_63", stall_err, 1);
        out_ready = 1'b1;
        tick;
        req_last = 4'b0100;
        tick;
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("stall_sticky", stall_err, 1);
        chk("stall_cnt2", cnt_of(2), 1);
        chk("stall_idle_grant", grant, 0);

        // Owner gap: source 3 drops Valid for 5 cycles mid-packet.
        do_reset;
        req_valid = 4'b1000;
        req_data  = {32'hB000_0000, 32'h0, 32'h0, 32'h0};
        tick;
        #1;
        chk("gap_b0_data", out_data, 32'hB000_0000);
        tick;
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("gap_%0d_valid", k), out_valid, 0);
            chk($sformatf("gap_%0d_grant", k), grant, 4'b1000);
            tick;
        end
        req_valid = 4'b1000;
        req_last  = 4'b1000;
        req_data  = {32'hB000_0001, 32'h0, 32'h0, 32'h0};
        #1;
        chk("gap_b1_valid", out_valid, 1);
        chk("gap_b1_data", out_data, 32'hB000_0001);
        chk("gap_b1_last", out_last, 1);
        tick;
        req_valid = '0;
        req_last  = '0;
        #1;
        chk("gap_cnt3", cnt_of(3), 1);
        chk("gap_idle_grant", grant, 0);

        // Reset mid-packet: source 0 served first so rr_ptr moves off its reset value.
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        req_data  = lanes(32'h2222_0001);
        tick;
        tick;
        req_valid = 4'b0100;
        req_last  = '0;
        tick;
        tick;
        req_data = lanes(32'h2222_0002);
        #1;
        chk("mid_pre_valid", out_valid, 1);
        chk("mid_pre_cnt0", cnt_of(0), 1);
        nreset = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_cnt", pkt_cnt, 0);
        req_valid = 4'b0011;
        #1;
        nreset = 1'b1;
        tick;
        #1;
        chk("mid_first_grant", grant, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ip_port_arbiter.md
Name: ip_port_arbiter

Overview:
- Round-robin, packet-granular arbiter that merges N_REQ fake IP injector streams onto one router local-port input (Valid/Data/Last/Ready).
- A grant is locked from the first beat to the Last beat of a packet, so packets from different sources never interleave.
- Also provides per-source accepted-packet counters and a sticky stall watchdog flag for the bring-up/LED logic.

Parameters:
- N_REQ, 4, number of requesting IP ports (2..8)
- DATA_WIDTH, 32, flit width (matches `DATA_WIDTH build option: 32 or 64)
- STALL_MAX, 63, idle cycles allowed inside a locked packet before stall_err sets (fits 6 bits)

Ports:
- clk  in  1  single clock
- nreset  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-source Valid
- req_data  in  N_REQ*DATA_WIDTH  per-source data; source i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  N_REQ  per-source Last
- req_ready  out  N_REQ  per-source Ready
- out_valid  out  1  Valid to router local port
- out_data  out  DATA_WIDTH  data to router
- out_last  out  1  Last to router
- out_ready  in  1  Ready from router
- grant  out  N_REQ  one-hot current owner; 0 when idle
- pkt_cnt  out  N_REQ*10  per-source count of completed packets, 10 bits each, wraps 1023->0
- stall_err  out  1  sticky: locked packet made no progress for STALL_MAX cycles

Behaviour:
- Clock/reset: one clock, clk. Reset is asynchronous and active-low on nreset.
- Beat: transfer occurs when out_valid && out_ready at posedge clk.
- Reset values:
  - state=IDLE, grant=0, rr_ptr=N_REQ-1
  - pkt_cnt all 0, stall_err=0, stall counter=0
  - out_valid=0, out_last=0, out_data=0, req_ready=0
- Reset asserted mid-packet aborts the packet; no partial state is retained.
- States: IDLE, LOCK.
- IDLE:
  - outputs inactive: out_valid=0, out_data=0, req_ready=0.
  - If any req_valid, pick the first valid source searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - Register that source into grant and go to LOCK.
  - Arbitration latency is 1 cycle from req_valid to out_valid.
- LOCK (owner g):
  - Combinational pass-through: out_valid=req_valid[g], out_data=req_data[g], out_last=req_last[g], req_ready[g]=out_ready. All other req_ready=0.
  - If the owner drops req_valid mid-packet, out_valid drops with it and the lock is held.
  - On a beat with out_last=1:
    - pkt_cnt[g]++ and rr_ptr<=g.
    - If any req_valid other than the current owner's own next packet, re-arbitrate in the same cycle from g+1 and stay in LOCK with the new grant (zero-bubble handover).
    - If only source g is valid, g is re-granted.
    - If no source is valid, go to IDLE and set grant=0.
- Fairness: after serving g, every other valid source is served before g again.
- Single-beat packet (valid and last on the first beat) is legal: it is counted, then arbitration proceeds as above.
- out_data must equal 0 whenever out_valid=0 in IDLE. In LOCK it passes req_data through regardless of req_valid.
- Stall watchdog:
  - 6-bit counter, cleared on every beat and in IDLE.
  - Increments in LOCK when no beat occurs.
  - When it reaches STALL_MAX, stall_err is set and the counter saturates.
  - stall_err clears only on reset. Arbitration continues unaffected.
- Simultaneous requests in IDLE are resolved by rr_ptr. The first grant after reset goes to source 0.
- req_valid from non-owners is ignored during LOCK. Their data is never forwarded and their ready stays 0.

Test Plan:
- Reset, then req_valid[2]=1 with a 4-beat packet (Last on beat 4), out_ready=1 -> grant=4'b0100 one cycle later; 4 beats pass unchanged; pkt_cnt[2]=1; then IDLE with grant=0.
- All 4 sources each hold a 2-beat packet continuously, out_ready=1 -> grant order 0,1,2,3,0 with no idle cycle between packets; after 8 packets every pkt_cnt=2.
- Source 1 locked; source 0 raises valid mid-packet -> req_ready[0]=0 and no source-0 data appears until source 1's Last beat completes.
- Locked packet with out_ready=0 held for 63 cycles -> stall_err=1 at cycle 63 and stays 1 after out_ready returns and the packet completes.
- Owner drops req_valid for 5 cycles mid-packet -> out_valid=0 for those cycles, grant unchanged, packet resumes intact.
- nreset pulsed low during beat 2 of a packet -> all outputs return to reset values immediately; afterwards source 0 wins first arbitration.
